node_sequencer: RTL and testbench
=================================

// Module: node_sequencer
// PURPOSE
//  Per-node controller that sits directly upstream of valueRouter in a QuickQ node.
//  Accepts insert/remove ops, sequences the router's mode codes and owns the node's
//  element count. Drives the node BRAM port (1-cycle read latency), forwards displaced
//  values to the next node and returns removed values to the requester.
// PARAMETERS
//  DATA_W      32  element width
//  CNT_W       8   count / array_size width
//  ADDR_W      8   BRAM address width
//  ARRAY_SIZE  5   node capacity; driven constant on array_size
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous, active-high reset
//  op_valid     in   1       op request
//  op_ready     out  1       = (state==IDLE); accept on op_valid&&op_ready
//  op_code      in   1       1=insert, 0=remove
//  op_data      in   DATA_W  value to insert
//  bram_addr    out  ADDR_W  BRAM address
//  bram_we      out  1       BRAM write strobe
//  bram_wdata   out  DATA_W  BRAM write data
//  bram_rdata   in   DATA_W  BRAM read data (valid 1 cycle after bram_addr)
//  mode         out  3       to router: 000 cmp-ins, 001 inc, 010 rm, 011 dec, 100 NOP
//  bram_out     out  DATA_W  to router: head value; 32'hFFFFFFFF when cnt==0
//  reg_out      out  DATA_W  to router: incoming/replacement value (hold_q)
//  array_size   out  CNT_W   to router: ARRAY_SIZE
//  array_cnt_in out  CNT_W   to router: cnt_q
//  bram_insert  in   DATA_W  from router: value for head slot
//  to_register  in   DATA_W  from router: displaced (loser) value
//  data_lt_o    in   DATA_W  from router: removed value
//  array_cnt_out in  CNT_W   from router: updated count
//  full         in   1       from router: count == size
//  fwd_valid    out  1       displaced value to next node
//  fwd_ready    in   1       next node accepts
//  fwd_data     out  DATA_W  displaced value
//  rsp_valid    out  1       remove response
//  rsp_ready    in   1       requester accepts
//  rsp_data     out  DATA_W  removed value (32'hFFFFFFFF if empty)
//  rsp_empty    out  1       remove attempted on empty node
// BEHAVIOUR
//  Reset: state=IDLE, cnt_q=0, hold_q=0, loser_q=0, rsp_q=0; mode=100, bram_we=0,
//   fwd_valid=0, rsp_valid=0, rsp_empty=0, bram_addr=0. Mid-op reset aborts immediately;
//   BRAM is not cleared but the node is logically empty.
//  Insert (accept at T; hold_q<=op_data): RD_HEAD(T+1) addr=0 -> CMP(T+2) mode=000,
//   bram_we=1 addr=0 wdata=bram_insert, loser_q<=to_register, was_full<=full ->
//   UPD(T+3) mode=001: if !was_full {cnt_q<=array_cnt_out; if old cnt>0 write loser_q to
//   addr old cnt} -> IDLE(T+4); if was_full, cnt_q unchanged -> FWD.
//  FWD: fwd_valid=1, fwd_data=loser_q held stable until fwd_ready; then IDLE.
//  Remove, cnt_q>0: RD_TAIL addr=cnt_q-1 -> RD_HEAD addr=0, hold_q<=bram_rdata (tail) ->
//   RM mode=010, bram_we addr0 wdata=bram_insert, rsp_q<=data_lt_o -> DEC mode=011,
//   cnt_q<=array_cnt_out -> RSP.
//  Remove, cnt_q==0: straight to RSP, rsp_data=FFFFFFFF, rsp_empty=1; no BRAM write,
//   cnt_q unchanged.
//  RSP: rsp_valid=1 until rsp_ready; then IDLE. Ops are never accepted outside IDLE.
//  mode=100 in IDLE/RD_*/FWD/RSP. bram_we is 1 only in the cycles listed above.
//  cnt_q never exceeds ARRAY_SIZE and never underflows.
// TESTING
//  1 reset; insert 2 on empty -> BRAM[0]=2, cnt=1, no fwd_valid, op_ready high at T+4.
//  2 insert 1 -> BRAM[0]=1, BRAM[1]=2, cnt=2.
//  3 fill to cnt=5 (head f657c062), insert f680d628 -> cnt stays 5, fwd_data=f680d628;
//    fwd_ready low 3 cycles -> fwd_valid, fwd_data stable, op_ready=0.
//  4 cnt=2, head 39b034ac, remove -> rsp_data=router data_lt_o, cnt=1, one BRAM[0] write.
//  5 remove at cnt=0 -> rsp_valid, rsp_data=FFFFFFFF, rsp_empty=1, no bram_we, cnt=0.
//  6 assert rst during FWD -> next cycle IDLE, fwd_valid=0, cnt=0, mode=100.

Source files
------------

// File: rtl/node_sequencer.sv
// Per-node QuickQ controller: sequences valueRouter mode codes around insert/remove ops,
// owns the element count, drives the node BRAM port and the forward/response channels.
module node_sequencer #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned ARRAY_SIZE = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_code,
    input  logic [DATA_W-1:0] op_data,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_we,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic [2:0]        mode,
    output logic [DATA_W-1:0] bram_out,
    output logic [DATA_W-1:0] reg_out,
    output logic [CNT_W-1:0]  array_size,
    output logic [CNT_W-1:0]  array_cnt_in,
    input  logic [DATA_W-1:0] bram_insert,
    input  logic [DATA_W-1:0] to_register,
    input  logic [DATA_W-1:0] data_lt_o,
    input  logic [CNT_W-1:0]  array_cnt_out,
    input  logic              full,
    output logic              fwd_valid,
    input  logic              fwd_ready,
    output logic [DATA_W-1:0] fwd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_empty
);

    localparam logic [2:0] ModeCmpIns = 3'b000;
    localparam logic [2:0] ModeInc    = 3'b001;
    localparam logic [2:0] ModeRm     = 3'b010;
    localparam logic [2:0] ModeDec    = 3'b011;
    localparam logic [2:0] ModeNop    = 3'b100;
    localparam logic [CNT_W-1:0] SizeCnt = CNT_W'(ARRAY_SIZE);

    typedef enum logic [3:0] {
        StIdle,
        StInsRdHead,
        StInsCmp,
        StInsUpd,
        StFwd,
        StRmRdTail,
        StRmRdHead,
        StRm,
        StRmDec,
        StRsp
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] loser_q, loser_d;
    logic [DATA_W-1:0] rsp_q, rsp_d;
    logic              was_full_q, was_full_d;
    logic              rsp_empty_q, rsp_empty_d;
    logic [2:0]        mode_q, mode_d;
    logic              bram_we_q, bram_we_d;
    logic [ADDR_W-1:0] bram_addr_q, bram_addr_d;
    logic              wsel_q, wsel_d;
    logic              fwd_valid_q, fwd_valid_d;
    logic              rsp_valid_q, rsp_valid_d;

    // Next state and datapath registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        loser_d     = loser_q;
        rsp_d       = rsp_q;
        was_full_d  = was_full_q;
        rsp_empty_d = rsp_empty_q;
        unique case (state_q)
            StIdle: begin
                if (op_valid) begin
                    if (op_code) begin
                        hold_d  = op_data;
                        state_d = StInsRdHead;
                    end else if (cnt_q == '0) begin
                        rsp_d       = '1;
                        rsp_empty_d = 1'b1;
                        state_d     = StRsp;
                    end else begin
                        rsp_empty_d = 1'b0;
                        state_d     = StRmRdTail;
                    end
                end
            end
            StInsRdHead: state_d = StInsCmp;
            StInsCmp: begin
                loser_d    = to_register;
                was_full_d = full;
                state_d    = StInsUpd;
            end
            StInsUpd: begin
                if (!was_full_q) begin
                    cnt_d   = (array_cnt_out > SizeCnt) ? SizeCnt : array_cnt_out;
                    state_d = StIdle;
                end else begin
                    state_d = StFwd;
                end
            end
            StFwd: if (fwd_ready) state_d = StIdle;
            StRmRdTail: state_d = StRmRdHead;
            StRmRdHead: begin
                hold_d  = bram_rdata;
                state_d = StRm;
            end
            StRm: begin
                rsp_d   = data_lt_o;
                state_d = StRmDec;
            end
            StRmDec: begin
                if (cnt_q != '0) cnt_d = array_cnt_out;
                state_d = StRsp;
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_empty_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        mode_d      = ModeNop;
        bram_we_d   = 1'b0;
        bram_addr_d = '0;
        wsel_d      = 1'b0;
        fwd_valid_d = 1'b0;
        rsp_valid_d = 1'b0;
        unique case (state_d)
            StInsCmp: begin
                mode_d    = ModeCmpIns;
                bram_we_d = 1'b1;
            end
            StInsUpd: begin
                mode_d      = ModeInc;
                bram_we_d   = !full && (cnt_q != '0);
                bram_addr_d = ADDR_W'(cnt_q);
                wsel_d      = 1'b1;
            end
            StFwd:      fwd_valid_d = 1'b1;
            StRmRdTail: bram_addr_d = ADDR_W'(cnt_q - CNT_W'(1));
            StRm: begin
                mode_d    = ModeRm;
                bram_we_d = 1'b1;
            end
            StRmDec:    mode_d = ModeDec;
            StRsp:      rsp_valid_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            hold_q      <= '0;
            loser_q     <= '0;
            rsp_q       <= '0;
            was_full_q  <= 1'b0;
            rsp_empty_q <= 1'b0;
            mode_q      <= ModeNop;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            wsel_q      <= 1'b0;
            fwd_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            loser_q     <= loser_d;
            rsp_q       <= rsp_d;
            was_full_q  <= was_full_d;
            rsp_empty_q <= rsp_empty_d;
            mode_q      <= mode_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            wsel_q      <= wsel_d;
            fwd_valid_q <= fwd_valid_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign op_ready     = (state_q == StIdle);
    assign bram_addr    = bram_addr_q;
    assign bram_we      = bram_we_q;
    // Head writes take the router result directly; the tail append writes the held loser.
    assign bram_wdata   = wsel_q ? loser_q : bram_insert;
    assign mode         = mode_q;
    assign bram_out     = (cnt_q == '0) ? '1 : bram_rdata;
    assign reg_out      = hold_q;
    assign array_size   = SizeCnt;
    assign array_cnt_in = cnt_q;
    assign fwd_valid    = fwd_valid_q;
    assign fwd_data     = loser_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_q;
    assign rsp_empty    = rsp_empty_q;

endmodule

// File: tb/tb_node_sequencer.sv
// Bench for node_sequencer: behavioural router stub and BRAM, op vectors checked through
// a scoreboard queue, plus hand sequences for forward backpressure and mid-op reset.
module tb_node_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0, op_code = 1'b0;
    logic [31:0] op_data = '0;
    logic        op_ready;
    logic [7:0]  bram_addr;
    logic        bram_we;
    logic [31:0] bram_wdata, bram_rdata, bram_out, reg_out;
    logic [2:0]  mode;
    logic [7:0]  array_size, array_cnt_in, r_cnt_out;
    logic [31:0] r_insert, r_to_reg, r_data_lt;
    logic        r_full;
    logic        fwd_valid, fwd_ready = 1'b0;
    logic [31:0] fwd_data;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_empty;
    logic [31:0] rsp_data;

    always #5 clk = ~clk;

    node_sequencer dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
        .op_data(op_data), .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata), .mode(mode), .bram_out(bram_out), .reg_out(reg_out),
        .array_size(array_size), .array_cnt_in(array_cnt_in), .bram_insert(r_insert),
        .to_register(r_to_reg), .data_lt_o(r_data_lt), .array_cnt_out(r_cnt_out),
        .full(r_full), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_empty(rsp_empty)
    );

    // Router stub: min goes to the head, max is displaced; remove replaces head with tail.
    always_comb begin
        r_insert  = '0;
        r_to_reg  = '0;
        r_data_lt = '0;
        r_cnt_out = array_cnt_in;
        r_full    = (array_cnt_in == array_size);
        case (mode)
            3'b000: begin
                r_insert = (reg_out < bram_out) ? reg_out : bram_out;
                r_to_reg = (reg_out < bram_out) ? bram_out : reg_out;
            end
            3'b001: r_cnt_out = array_cnt_in + 8'd1;
            3'b010: begin
                r_insert  = reg_out;
                r_data_lt = bram_out;
            end
            3'b011: r_cnt_out = array_cnt_in - 8'd1;
            default: ;
        endcase
    end

    logic [31:0] mem [0:255];
    int wr_cnt = 0;
    always @(posedge clk) begin
        if (bram_we) begin
            mem[bram_addr] <= bram_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        bram_rdata <= mem[bram_addr];
    end

    typedef struct {
        bit          rst_before;
        bit          code;
        logic [31:0] data;
        logic [31:0] rsp;
        bit          empty;
        bit          fwd;
        logic [31:0] fwd_data;
        logic [7:0]  cnt;
        logic [31:0] head;
        int          writes;
        int          hold;
    } vec_t;

    localparam int NV = 16;
    vec_t tv [NV];
    vec_t sb [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t e;
        int lat, w0;
        logic [31:0] fd0;
        if (tv[i].rst_before) do_reset();
        @(negedge clk);
        chk($sformatf("v%0d op_ready_idle", i), {31'b0, op_ready}, 32'd1);
        w0 = wr_cnt;
        sb.push_back(tv[i]);
        op_valid = 1'b1;
        op_code  = tv[i].code;
        op_data  = tv[i].data;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        lat = 1;
        while (!(rsp_valid || fwd_valid || (op_ready && tv[i].code)) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d timeout", i), {31'b0, lat < 20}, 32'd1);
        if (e.fwd) begin
            chk($sformatf("v%0d fwd_valid", i), {31'b0, fwd_valid}, 32'd1);
            chk($sformatf("v%0d fwd_data", i), fwd_data, e.fwd_data);
            fd0 = fwd_data;
            for (int h = 0; h < e.hold; h++) begin
                @(negedge clk);
                chk($sformatf("v%0d fwd_hold_valid", i), {31'b0, fwd_valid}, 32'd1);
                chk($sformatf("v%0d fwd_hold_data", i), fwd_data, fd0);
                chk($sformatf("v%0d fwd_hold_busy", i), {31'b0, op_ready}, 32'd0);
            end
            fwd_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            fwd_ready = 1'b0;
        end else if (!e.code) begin
            chk($sformatf("v%0d rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
            chk($sformatf("v%0d rsp_data", i), rsp_data, e.rsp);
            chk($sformatf("v%0d rsp_empty", i), {31'b0, rsp_empty}, {31'b0, e.empty});
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end else begin
            chk($sformatf("v%0d ins_latency", i), lat, 32'd4);
            chk($sformatf("v%0d no_fwd", i), {31'b0, fwd_valid}, 32'd0);
        end
        chk($sformatf("v%0d back_idle", i), {31'b0, op_ready}, 32'd1);
        chk($sformatf("v%0d cnt", i), {24'b0, array_cnt_in}, {24'b0, e.cnt});
        chk($sformatf("v%0d head", i), mem[0], e.head);
        chk($sformatf("v%0d bram_writes", i), wr_cnt - w0, e.writes);
        chk($sformatf("v%0d mode_nop", i), {29'b0, mode}, 32'd4);
    endtask

    initial begin
        int lat;
        //          rst   code  data          rsp           emp  fwd  fwd_data      cnt  head      wr hold
        tv[0]  = '{1'b0, 1'b1, 32'h2,        32'h0,        1'b0, 1'b0, 32'h0,       8'd1, 32'h2,        1, 0};
        tv[1]  = '{1'b0, 1'b1, 32'h1,        32'h0,        1'b0, 1'b0, 32'h0,       8'd2, 32'h1,        2, 0};
        tv[2]  = '{1'b0, 1'b1, 32'h5,        32'h0,        1'b0, 1'b0, 32'h0,       8'd3, 32'h1,        2, 0};
        tv[3]  = '{1'b0, 1'b0, 32'h0,        32'h1,        1'b0, 1'b0, 32'h0,       8'd2, 32'h5,        1, 0};
        tv[4]  = '{1'b0, 1'b0, 32'h0,        32'h5,        1'b0, 1'b0, 32'h0,       8'd1, 32'h2,        1, 0};
        tv[5]  = '{1'b0, 1'b0, 32'h0,        32'h2,        1'b0, 1'b0, 32'h0,       8'd0, 32'h2,        1, 0};
        tv[6]  = '{1'b0, 1'b0, 32'h0,        32'hffffffff, 1'b1, 1'b0, 32'h0,       8'd0, 32'h2,        0, 0};
        tv[7]  = '{1'b0, 1'b1, 32'h39b034ac, 32'h0,        1'b0, 1'b0, 32'h0,       8'd1, 32'h39b034ac, 1, 0};
        tv[8]  = '{1'b0, 1'b1, 32'h40000000, 32'h0,        1'b0, 1'b0, 32'h0,       8'd2, 32'h39b034ac, 2, 0};
        tv[9]  = '{1'b0, 1'b0, 32'h0,        32'h39b034ac, 1'b0, 1'b0, 32'h0,       8'd1, 32'h40000000, 1, 0};
        tv[10] = '{1'b1, 1'b1, 32'hf7000000, 32'h0,        1'b0, 1'b0, 32'h0,       8'd1, 32'hf7000000, 1, 0};
        tv[11] = '{1'b0, 1'b1, 32'hf657c062, 32'h0,        1'b0, 1'b0, 32'h0,       8'd2, 32'hf657c062, 2, 0};
        tv[12] = '{1'b0, 1'b1, 32'hf8000000, 32'h0,        1'b0, 1'b0, 32'h0,       8'd3, 32'hf657c062, 2, 0};
        tv[13] = '{1'b0, 1'b1, 32'hf9000000, 32'h0,        1'b0, 1'b0, 32'h0,       8'd4, 32'hf657c062, 2, 0};
        tv[14] = '{1'b0, 1'b1, 32'hfa000000, 32'h0,        1'b0, 1'b0, 32'h0,       8'd5, 32'hf657c062, 2, 0};
        tv[15] = '{1'b0, 1'b1, 32'hf680d628, 32'h0,        1'b0, 1'b1, 32'hf680d628, 8'd5, 32'hf657c062, 1, 3};

        repeat (3) @(negedge clk);
        chk("reset op_ready", {31'b0, op_ready}, 32'd1);
        chk("reset mode", {29'b0, mode}, 32'd4);
        chk("reset bram_we", {31'b0, bram_we}, 32'd0);
        chk("reset bram_addr", {24'b0, bram_addr}, 32'd0);
        chk("reset fwd_valid", {31'b0, fwd_valid}, 32'd0);
        chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset rsp_empty", {31'b0, rsp_empty}, 32'd0);
        chk("reset cnt", {24'b0, array_cnt_in}, 32'd0);
        chk("reset array_size", {24'b0, array_size}, 32'd5);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        // Node is full: another insert forwards, then reset lands in the middle of FWD.
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 1'b1;
        op_data  = 32'hfb000000;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        lat = 1;
        while (!fwd_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("rstfwd reach_fwd", {31'b0, fwd_valid}, 32'd1);
        chk("rstfwd fwd_data", fwd_data, 32'hfb000000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstfwd op_ready", {31'b0, op_ready}, 32'd1);
        chk("rstfwd fwd_valid", {31'b0, fwd_valid}, 32'd0);
        chk("rstfwd cnt", {24'b0, array_cnt_in}, 32'd0);
        chk("rstfwd mode", {29'b0, mode}, 32'd4);
        chk("rstfwd bram_we", {31'b0, bram_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // After the abort the node is logically empty, so a remove reports empty.
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        chk("post_rst rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("post_rst rsp_empty", {31'b0, rsp_empty}, 32'd1);
        chk("post_rst rsp_data", rsp_data, 32'hffffffff);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rst idle", {31'b0, op_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
